// File: rtl/sum_latch_tx_sequencer_if.sv
// Byte-wide UART transmit handshake between the sequencer and the UART TX.
// The master drives tx_start and tx_data. The slave, which is the UART, answers on tx_busy.
interface sum_latch_tx_sequencer_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (output tx_start, output tx_data, input tx_busy);
  modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/sum_latch_tx_sequencer.sv
// sum_latch_tx_sequencer
//
// On a start strobe this block captures two 8-bit operands and latches their 9-bit sum.
// It then sends the frame {HEADER, sum[7:0], {7'b0, sum[8]}} through a byte-wide UART.
// The UART handshake is a one-cycle tx_start pulse followed by tx_busy.
//
// Optional build macro SUMLATCH_CHECKSUM_EN appends a fourth byte.
// That byte is the XOR of the first three bytes. It is computed when the sum is latched.
//
// After each tx_start, one GUARD cycle ignores tx_busy. This covers the UART's one-cycle busy latency.
// Each WAIT phase is bounded by TIMEOUT cycles.
// If the bound expires, the frame is abandoned and the sticky err flag is set.
module sum_latch_tx_sequencer #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         TIMEOUT = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [7:0]                      a_in,
  input  logic [7:0]                      b_in,
  sum_latch_tx_sequencer_if.master        tx,
  output logic [8:0]                      sum_out,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic                            dropped
);

`ifdef SUMLATCH_CHECKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GUARD = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [1:0]       idx_r;
  logic [1:0]       idx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             latch_s;
  logic             err_set_s;
  logic             drop_set_s;
  logic [8:0]       sum_s;
  logic [7:0]       byte_s;
  logic             tx_start_r;
  logic [7:0]       tx_data_r;

`ifdef SUMLATCH_CHECKSUM_EN
  logic [7:0] chk_r;

  // XOR checksum over the three leading frame bytes
  function automatic logic [7:0] frame_checksum(input logic [7:0] b0,
                                                input logic [7:0] b1,
                                                input logic [7:0] b2);
    return b0 ^ b1 ^ b2;
  endfunction
`endif

  assign sum_s       = {1'b0, a_in} + {1'b0, b_in};
  assign tx.tx_start = tx_start_r;
  assign tx.tx_data  = tx_data_r;

  // Next-state, byte index, WAIT counter and sticky-flag set conditions
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    cnt_s      = cnt_r;
    latch_s    = 1'b0;
    err_set_s  = 1'b0;
    drop_set_s = start && (state_r != IDLE);
    case (state_r)
      IDLE: begin
        if (start) begin
          latch_s = 1'b1;
          idx_s   = 2'd0;
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        cnt_s   = {CNT_W{1'b0}};
        state_s = GUARD;
      end
      GUARD: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (!tx.tx_busy) begin
          if (idx_r == LAST_IDX) begin
            state_s = DONE;
          end else begin
            idx_s   = idx_r + 2'd1;
            state_s = LOAD;
          end
        end else if (cnt_r == CNT_LAST) begin
          err_set_s = 1'b1;
          state_s   = IDLE;
        end else begin
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Byte that will be presented on the next LOAD cycle; index 0 is the header, so the not-yet-latched sum is irrelevant there
  always_comb begin
    byte_s = 8'h00;
    case (idx_s)
      2'd0:    byte_s = HEADER;
      2'd1:    byte_s = sum_out[7:0];
      2'd2:    byte_s = {7'b0000000, sum_out[8]};
`ifdef SUMLATCH_CHECKSUM_EN
      2'd3:    byte_s = chk_r;
`endif
      default: byte_s = 8'h00;
    endcase
  end

  // State register plus registered outputs, all derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= 2'd0;
      cnt_r      <= {CNT_W{1'b0}};
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
      sum_out    <= 9'h000;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      cnt_r      <= cnt_s;
      tx_start_r <= (state_s == LOAD);
      busy       <= (state_s != IDLE);
      done       <= (state_s == DONE);
      err        <= err | err_set_s;
      dropped    <= dropped | drop_set_s;
      if (state_s == LOAD) begin
        tx_data_r <= byte_s;
      end
      if (latch_s) begin
        sum_out <= sum_s;
      end
    end
  end

`ifdef SUMLATCH_CHECKSUM_EN
  // Checksum byte is latched together with the sum so it stays consistent with sum_out
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_r <= 8'h00;
    end else if (latch_s) begin
      chk_r <= frame_checksum(HEADER, sum_s[7:0], {7'b0000000, sum_s[8]});
    end
  end
`endif

endmodule

// File: tb/tb_sum_latch_tx_sequencer.sv
// Self-checking bench for sum_latch_tx_sequencer.
// A UART model raises busy one cycle after tx_start and holds it for 10 cycles.
// Build with SUMLATCH_CHECKSUM_EN to exercise the four-byte frame.
module tb_sum_latch_tx_sequencer;

`ifdef SUMLATCH_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic [8:0] sum_out;
  logic       busy;
  logic       done;
  logic       err;
  logic       dropped;

  sum_latch_tx_sequencer_if tx_if();

  sum_latch_tx_sequencer #(.HEADER(8'hA5), .TIMEOUT(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .tx      (tx_if),
    .sum_out (sum_out),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .dropped (dropped)
  );

  always #5 clk = ~clk;

  // UART model
  logic ubusy      = 1'b0;
  int   ucnt       = 0;
  int   hold_len   = 10;
  logic uart_stuck = 1'b0;
  logic glitch_low = 1'b0;

  assign tx_if.tx_busy = ubusy & ~glitch_low;

  always @(posedge clk) begin
    if (tx_if.tx_start === 1'b1) begin
      ubusy <= 1'b1;
      ucnt  <= hold_len;
    end else if (ucnt > 1) begin
      ucnt <= ucnt - 1;
    end else begin
      ucnt  <= 0;
      ubusy <= uart_stuck ? ubusy : 1'b0;
    end
  end

  // Monitor: collect sent bytes and count protocol events
  logic [7:0] bytes[$];
  int   n_txs       = 0;
  int   n_done      = 0;
  int   multi_start = 0;
  int   overlap     = 0;
  int   wide_done   = 0;
  logic prev_ts     = 1'b0;
  logic prev_done   = 1'b0;

  always @(negedge clk) begin
    if (tx_if.tx_start === 1'b1) begin
      bytes.push_back(tx_if.tx_data);
      n_txs++;
      if (prev_ts) multi_start++;
      if (ubusy) overlap++;
    end
    if (done === 1'b1) begin
      n_done++;
      if (prev_done) wide_done++;
    end
    prev_ts   = (tx_if.tx_start === 1'b1);
    prev_done = (done === 1'b1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    tick();
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && busy === 1'b1; i++) tick();
    check($sformatf("%s_idle", name), busy, 1'b0);
  endtask

  task automatic wait_txs(input int target, input string name);
    for (int i = 0; i < 400 && n_txs < target; i++) tick();
    check($sformatf("%s_txs_reached", name), (n_txs >= target), 1'b1);
  endtask

  task automatic check_frame(input string name, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hA5;
    exp_b[1] = e1;
    exp_b[2] = e2;
    exp_b[3] = e3;
    check($sformatf("%s_nbytes", name), bytes.size(), NB);
    for (int i = 0; i < NB; i++) begin
      if (i < bytes.size()) check($sformatf("%s_byte%0d", name, i), bytes[i], exp_b[i]);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check($sformatf("%s_tx_start", name), tx_if.tx_start, 1'b0);
    check($sformatf("%s_tx_data", name), tx_if.tx_data, 8'h00);
    check($sformatf("%s_sum_out", name), sum_out, 9'h000);
    check($sformatf("%s_busy", name), busy, 1'b0);
    check($sformatf("%s_done", name), done, 1'b0);
    check($sformatf("%s_err", name), err, 1'b0);
    check($sformatf("%s_dropped", name), dropped, 1'b0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] sum;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int base_done;
    int base_tx;
    int nt;

    vecs[0] = '{a: 8'h12, b: 8'h34, sum: 9'h046, b1: 8'h46, b2: 8'h00, b3: 8'hE3};
    vecs[1] = '{a: 8'hFF, b: 8'hFF, sum: 9'h1FE, b1: 8'hFE, b2: 8'h01, b3: 8'h5A};
    vecs[2] = '{a: 8'h00, b: 8'h00, sum: 9'h000, b1: 8'h00, b2: 8'h00, b3: 8'hA5};
    vecs[3] = '{a: 8'h80, b: 8'h80, sum: 9'h100, b1: 8'h00, b2: 8'h01, b3: 8'hA4};
    vecs[4] = '{a: 8'h7F, b: 8'h01, sum: 9'h080, b1: 8'h80, b2: 8'h00, b3: 8'h25};

    rst   = 1'b1;
    start = 1'b0;
    a_in  = 8'h00;
    b_in  = 8'h00;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      bytes.delete();
      base_done = n_done;
      pulse_start(vecs[v].a, vecs[v].b);
      check($sformatf("v%0d_latency", v), tx_if.tx_start, 1'b1);
      wait_idle($sformatf("v%0d", v));
      check($sformatf("v%0d_sum", v), sum_out, vecs[v].sum);
      check_frame($sformatf("v%0d", v), vecs[v].b1, vecs[v].b2, vecs[v].b3);
      check($sformatf("v%0d_done_count", v), n_done - base_done, 1);
      check($sformatf("v%0d_err", v), err, 1'b0);
      check($sformatf("v%0d_dropped", v), dropped, 1'b0);
      check($sformatf("v%0d_tx_data_hold", v), tx_if.tx_data, (NB == 4) ? vecs[v].b3 : vecs[v].b2);
    end

    // tx_busy glitch low during GUARD must not advance the byte index
    bytes.delete();
    base_done = n_done;
    pulse_start(8'h12, 8'h34);
    tick();
    glitch_low = 1'b1;
    tick();
    glitch_low = 1'b0;
    wait_idle("glitch");
    check_frame("glitch", 8'h46, 8'h00, 8'hE3);
    check("glitch_overlap", overlap, 0);
    check("glitch_done_count", n_done - base_done, 1);

    // Start arriving mid-frame is dropped
    bytes.delete();
    base_tx = n_txs;
    pulse_start(8'h12, 8'h34);
    wait_txs(base_tx + 2, "drop");
    repeat (5) tick();
    pulse_start(8'h55, 8'h11);
    wait_idle("drop");
    check_frame("drop", 8'h46, 8'h00, 8'hE3);
    check("drop_dropped", dropped, 1'b1);
    check("drop_sum_kept", sum_out, 9'h046);
    bytes.delete();
    pulse_start(8'h20, 8'h30);
    wait_idle("after_drop");
    check("after_drop_sum", sum_out, 9'h050);
    check_frame("after_drop", 8'h50, 8'h00, 8'hF5);
    check("after_drop_dropped_sticky", dropped, 1'b1);

    // Timeout with tx_busy stuck high
    uart_stuck = 1'b1;
    base_done = n_done;
    base_tx = n_txs;
    pulse_start(8'h12, 8'h34);
    check("to_tx_start", tx_if.tx_start, 1'b1);
    repeat (17) tick();
    check("to_err_before", err, 1'b0);
    check("to_busy_before", busy, 1'b1);
    tick();
    check("to_err_set", err, 1'b1);
    check("to_busy_low", busy, 1'b0);
    check("to_no_done", n_done - base_done, 0);
    check("to_one_byte", n_txs - base_tx, 1);
    uart_stuck = 1'b0;
    repeat (3) tick();
    bytes.delete();
    pulse_start(8'h01, 8'h01);
    wait_idle("after_to");
    check_frame("after_to", 8'h02, 8'h00, 8'hA7);
    check("after_to_err_sticky", err, 1'b1);

    // Reset during the second byte's WAIT
    bytes.delete();
    base_tx = n_txs;
    pulse_start(8'h12, 8'h34);
    wait_txs(base_tx + 2, "rst");
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    nt = n_txs;
    repeat (15) tick();
    check("midrst_no_tx", n_txs, nt);
    bytes.delete();
    base_done = n_done;
    pulse_start(8'h01, 8'h02);
    wait_idle("post_rst");
    check("post_rst_sum", sum_out, 9'h003);
    check_frame("post_rst", 8'h03, 8'h00, 8'hA6);
    check("post_rst_done_count", n_done - base_done, 1);

    check("tx_start_single_cycle", multi_start, 0);
    check("done_single_cycle", wide_done, 0);
    check("no_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sum_latch_tx_sequencer.md
Name: sum_latch_tx_sequencer

Overview:
Controller that sequences the sum/latch/UART datapath.
- On a start strobe it captures two 8-bit operands, computes and latches the 9-bit sum.
- It then drives the existing byte-wide UART transmitter through a start/busy handshake to emit a fixed frame.
- It sits between the top-level input pins and the UART TX instance, and owns all transmit sequencing.

Parameters:
HEADER, 8'hA5, first byte of every frame
TIMEOUT, 4096, max cycles to wait for tx_busy to fall per byte before aborting (≥2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request; capture operands and send a frame
a_in  input  8  operand A
b_in  input  8  operand B
tx_busy  input  1  UART transmitter busy; asserted the cycle after tx_start and held until the byte is done
tx_start  output  1  one-cycle pulse; tx_data valid in the same cycle
tx_data  output  8  byte to transmit
sum_out  output  9  latched sum A+B
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse after the last byte completes
err  output  1  sticky; set on timeout
dropped  output  1  sticky; set when start arrives while busy

Behaviour:
- Reset (clk edge with rst=1):
  - State=IDLE.
  - tx_start=0, tx_data=0, sum_out=0, busy=0, done=0, err=0, dropped=0.
  - Byte index and timeout counter cleared.
- Reset overrides everything, including mid-frame: tx_start is low on the next edge and the frame is abandoned. The sequencer does not try to abort a UART byte already in flight.
- Frame bytes:
  - B0=HEADER
  - B1=sum[7:0]
  - B2={7'b0,sum[8]}
  - N=3 bytes, or 4 with the optional checksum.
- Sum arithmetic: sum = {1'b0,a_in} + {1'b0,b_in}, 9 bits, no truncation.
- States:
  - IDLE: start=1 → latch sum_out at this edge, idx=0, go to LOAD. start=0 → stay.
  - LOAD: tx_data=byte[idx], tx_start=1 for exactly this one cycle, timeout counter cleared → GUARD.
  - GUARD: one cycle; tx_busy is ignored here, to cover the UART's one-cycle busy latency → WAIT.
  - WAIT: counter increments each cycle.
    - tx_busy=0 and idx<N-1 → idx+1, go to LOAD.
    - tx_busy=0 and idx=N-1 → go to DONE.
    - counter reaches TIMEOUT-1 while tx_busy=1 → err=1, go to IDLE, no done pulse.
  - DONE: done=1 for one cycle → IDLE.
- Latency:
  - start to the first tx_start is 1 cycle (tx_start high in the cycle after start is sampled).
  - Gap between the end of a byte (tx_busy falls) and the next tx_start is 1 cycle.
- sum_out holds its value until the next accepted start; it stays valid after done and after err.
- tx_data holds the last byte sent; it only changes in LOAD.
- start while busy=1, including DONE: ignored, dropped=1 (sticky until reset). Operands are not re-latched.
- start in the same cycle as a timeout exit: ignored, dropped=1. The next start is accepted only from IDLE.
- err and dropped clear only on reset.
- a_in and b_in are sampled only at the accepting edge; changes during a frame have no effect.

Optional Feature:
Macro: SUMLATCH_CHECKSUM_EN
- Defined: N=4, and B3 = B0^B1^B2. B3 is computed at the latch edge and held with sum_out.
- Not defined: N=3, and no checksum logic is present.
- All other timing is identical in both builds.

Test Plan:
1. Reset, then start with a_in=0x12, b_in=0x34, using a UART model (busy 1 cycle after tx_start, held 10 cycles):
   - bytes A5,46,00; sum_out=0x046; one done pulse; busy low afterwards.
   - With the macro: 4th byte E3.
2. a_in=0xFF, b_in=0xFF:
   - sum_out=0x1FE; bytes A5,FE,01.
   - With the macro: 4th byte 5A.
3. Start pulse at cycle 5 of the second byte:
   - frame unchanged; dropped=1; sum_out unchanged.
   - A later start from IDLE is accepted normally.
4. UART model holds tx_busy=1 indefinitely with TIMEOUT=16:
   - err=1 exactly 16 WAIT cycles after entering WAIT; state IDLE; no done pulse.
   - A next start sends a full frame with err still 1.
5. Assert rst during the second byte's WAIT:
   - next edge shows all outputs at reset values; no further tx_start.
   - Then start with 0x01+0x02 → bytes A5,03,00.
6. Check tx_start is high for exactly 1 cycle per byte, and that a tx_busy glitch low in the GUARD cycle does not advance idx.
